// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encodings and FSM state constants for the
// 4-digit decimal calculator.
package calc_pkg;

  localparam int MAX_VALUE = 9999;

  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MULT = 4'd12;
  localparam logic [3:0] KEY_DIV  = 4'd13;
  localparam logic [3:0] KEY_EQ   = 4'd14;
  localparam logic [3:0] KEY_CLR  = 4'd15;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  localparam logic [2:0] ENTER_A = 3'd0;
  localparam logic [2:0] ENTER_B = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] SHOW    = 3'd4;

  function automatic logic is_digit(input logic [3:0] k);
    return k < 4'd10;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

endpackage

// File: rtl/digit_accum.sv
// Digit counter plus the value*10+digit step, shared by both operands;
// the caller supplies whichever operand is currently being entered.
module digit_accum #(
  parameter int WIDTH      = 14,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set_one,
  input  logic             step,
  input  logic [WIDTH-1:0] cur_val,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] next_val,
  output logic             accept,
  output logic             empty
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [CW-1:0] count;

  assign accept   = count < CW'(MAX_DIGITS);
  assign empty    = count == '0;
  assign next_val = cur_val * WIDTH'(10) + WIDTH'(digit);

  // A digit only advances the count while there is room; set_one restarts
  // entry with the first digit already consumed.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (set_one)
      count <= CW'(1);
    else if (step && accept)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/calc_controller.sv
// Keypad sequencing FSM: builds operands, fires the ALU, checks range
// errors itself and presents the registered result.
module calc_controller #(
  parameter int WIDTH       = 14,
  parameter int MAX_DIGITS  = 4,
  parameter int MAX_VALUE   = calc_pkg::MAX_VALUE,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] operator1,
  output logic [WIDTH-1:0] operator2,
  output logic [1:0]       operation_val,
  output logic             op_enable,
  output logic             eq_enable,
  output logic [WIDTH-1:0] display_val,
  output logic             err,
  output logic             busy
);

  import calc_pkg::*;

  localparam int WCW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  logic [2:0]         state;
  logic [WCW-1:0]     wait_cnt;
  logic               err_pend;
  logic               exec_err;
  logic               key_digit, key_op, key_eq, do_clear, entering;
  logic [WIDTH-1:0]   acc_next;
  logic               acc_accept, acc_empty;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  assign entering  = (state == ENTER_A) || (state == ENTER_B) || (state == SHOW);
  assign key_digit = key_valid && is_digit(key_code);
  assign key_op    = key_valid && is_op(key_code);
  assign key_eq    = key_valid && (key_code == KEY_EQ);
  assign do_clear  = key_valid && (key_code == KEY_CLR) && entering;

  digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (do_clear || (key_op && ((state == ENTER_A) || (state == SHOW)))),
    .set_one  (key_digit && (state == SHOW)),
    .step     (key_digit && ((state == ENTER_A) || (state == ENTER_B))),
    .cur_val  ((state == ENTER_B) ? operator2 : operator1),
    .digit    (key_code),
    .next_val (acc_next),
    .accept   (acc_accept),
    .empty    (acc_empty)
  );

  // Full-width sum and product so overflow is judged before any truncation.
  assign sum     = {1'b0, operator1} + {1'b0, operator2};
  assign product = {{WIDTH{1'b0}}, operator1} * {{WIDTH{1'b0}}, operator2};

  always_comb begin
    exec_err = 1'b0;
    case (operation_val)
      OP_ADD:  exec_err = sum > (WIDTH+1)'(MAX_VALUE);
      OP_SUB:  exec_err = operator2 > operator1;
      OP_MULT: exec_err = product > (2*WIDTH)'(MAX_VALUE);
      OP_DIV:  exec_err = operator2 == '0;
      default: exec_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || do_clear) begin
      state         <= ENTER_A;
      operator1     <= '0;
      operator2     <= '0;
      operation_val <= '0;
      display_val   <= '0;
      op_enable     <= 1'b0;
      eq_enable     <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      err_pend      <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      op_enable <= 1'b0;
      eq_enable <= 1'b0;
      case (state)
        ENTER_A: begin
          if (key_digit && acc_accept) begin
            operator1   <= acc_next;
            display_val <= acc_next;
          end else if (key_op) begin
            operation_val <= 2'(key_code - KEY_ADD);
            operator2     <= '0;
            state         <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_digit && acc_accept) begin
            operator2   <= acc_next;
            display_val <= acc_next;
          end else if (key_op && acc_empty) begin
            operation_val <= 2'(key_code - KEY_ADD);
          end else if (key_eq && !acc_empty) begin
            op_enable <= 1'b1;
            eq_enable <= 1'b1;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          err_pend <= exec_err;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WCW'(ALU_LATENCY)) begin
            // An error result zeroes A so a chained operation starts clean.
            operator1   <= err_pend ? '0 : alu_result;
            display_val <= err_pend ? WIDTH'(MAX_VALUE) : alu_result;
            err         <= err_pend;
            busy        <= 1'b0;
            state       <= SHOW;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        SHOW: begin
          if (key_digit) begin
            operator1   <= WIDTH'(key_code);
            display_val <= WIDTH'(key_code);
            err         <= 1'b0;
            state       <= ENTER_A;
          end else if (key_op) begin
            if (err)
              operator1 <= '0;
            operation_val <= 2'(key_code - KEY_ADD);
            operator2     <= '0;
            err           <= 1'b0;
            state         <= ENTER_B;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: directed key sequences with
// literal expectations, then random keys checked against a behavioural model.
module tb_calc_controller;

  localparam int WIDTH = 14;
  localparam int LAT   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_valid;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] alu_result = '0;
  logic [WIDTH-1:0] operator1, operator2, display_val;
  logic [1:0]       operation_val;
  logic             op_enable, eq_enable, err, busy;

  int checks   = 0;
  int failures = 0;
  bit check_on = 1'b0;

  // Model: mode 0 = entering A, 1 = entering B, 2 = busy, 3 = showing result
  int m_a, m_b, m_op, m_cnt, m_disp, m_err, m_busy, m_open, m_mode, m_remain;
  int m_res, m_res_err;

  always #5 clk = ~clk;

  calc_controller #(.WIDTH(WIDTH), .MAX_DIGITS(4), .MAX_VALUE(9999), .ALU_LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .alu_result    (alu_result),
    .operator1     (operator1),
    .operator2     (operator2),
    .operation_val (operation_val),
    .op_enable     (op_enable),
    .eq_enable     (eq_enable),
    .display_val   (display_val),
    .err           (err),
    .busy          (busy)
  );

  // Registered ALU with wrap-around arithmetic, as a real 14-bit ALU would do
  always @(posedge clk) begin
    if (op_enable) begin
      case (operation_val)
        2'd0: alu_result <= operator1 + operator2;
        2'd1: alu_result <= operator1 - operator2;
        2'd2: alu_result <= operator1 * operator2;
        default: alu_result <= (operator2 == '0) ? '0 : operator1 / operator2;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      checkOutput("operator1", operator1, m_a);
      checkOutput("operator2", operator2, m_b);
      checkOutput("operation_val", operation_val, m_op);
      checkOutput("op_enable", op_enable, m_open);
      checkOutput("eq_enable", eq_enable, m_open);
      checkOutput("display_val", display_val, m_disp);
      checkOutput("err", err, m_err);
      checkOutput("busy", busy, m_busy);
    end
  end

  task automatic modelReset();
    m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_disp = 0; m_err = 0;
    m_busy = 0; m_open = 0; m_mode = 0; m_remain = 0;
  endtask

  task automatic modelStep(input bit kv, input int kc, input bit r);
    if (r) begin
      modelReset();
      return;
    end
    m_open = 0;
    if (m_mode == 2) begin
      m_remain--;
      if (m_remain == 0) begin
        m_a    = m_res_err ? 0 : m_res;
        m_disp = m_res_err ? 9999 : m_res;
        m_err  = m_res_err;
        m_busy = 0;
        m_mode = 3;
      end
      return;
    end
    if (!kv) return;
    if (kc == 15) begin
      modelReset();
      return;
    end
    case (m_mode)
      0: begin
        if (kc < 10 && m_cnt < 4) begin
          m_a = m_a * 10 + kc; m_cnt++; m_disp = m_a;
        end else if (kc >= 10 && kc <= 13) begin
          m_op = kc - 10; m_b = 0; m_cnt = 0; m_mode = 1;
        end
      end
      1: begin
        if (kc < 10 && m_cnt < 4) begin
          m_b = m_b * 10 + kc; m_cnt++; m_disp = m_b;
        end else if (kc >= 10 && kc <= 13 && m_cnt == 0) begin
          m_op = kc - 10;
        end else if (kc == 14 && m_cnt > 0) begin
          case (m_op)
            0: begin m_res = m_a + m_b; m_res_err = (m_res > 9999); end
            1: begin m_res = m_a - m_b; m_res_err = (m_b > m_a); end
            2: begin m_res = m_a * m_b; m_res_err = (m_res > 9999); end
            default: begin
              m_res_err = (m_b == 0);
              m_res = m_res_err ? 0 : m_a / m_b;
            end
          endcase
          m_open = 1; m_busy = 1; m_remain = 2 + LAT; m_mode = 2;
        end
      end
      default: begin
        if (kc < 10) begin
          m_a = kc; m_cnt = 1; m_err = 0; m_disp = kc; m_mode = 0;
        end else if (kc >= 10 && kc <= 13) begin
          if (m_err != 0) m_a = 0;
          m_op = kc - 10; m_b = 0; m_cnt = 0; m_err = 0; m_mode = 1;
        end
      end
    endcase
  endtask

  // One clock: drive inputs away from the edge, advance the model on the edge
  task automatic applyStimulus(input bit kv, input int kc, input bit r);
    key_valid = kv;
    key_code  = 4'(kc);
    rst       = r;
    @(posedge clk);
    modelStep(kv, kc, r);
    #1;
  endtask

  task automatic key(input int kc);
    applyStimulus(1'b1, kc, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
  endtask

  task automatic keys(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    modelReset();
    rst = 1'b1; key_valid = 1'b0; key_code = '0;
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1);
    check_on = 1'b1;
    @(negedge clk);
    checkOutput("reset_display", display_val, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_operator1", operator1, 0);

    // 12 + 34 with exact latency
    keys(1, 2, 10, 3); key(4); key(14);
    @(negedge clk);
    checkOutput("add_op_enable", op_enable, 1);
    checkOutput("add_operator1", operator1, 12);
    checkOutput("add_operator2", operator2, 34);
    checkOutput("add_operation", operation_val, 0);
    idle(2);
    @(negedge clk);
    checkOutput("add_not_yet", display_val, 34);
    idle(1);
    @(negedge clk);
    checkOutput("add_result", display_val, 46);
    checkOutput("add_err", err, 0);

    // Fifth digit ignored, then overflowing product
    key(15); keys(1, 2, 3, 4); key(5);
    @(negedge clk);
    checkOutput("fifth_digit", display_val, 1234);
    key(12); key(9); key(14); idle(3);
    @(negedge clk);
    checkOutput("mult_err", err, 1);
    checkOutput("mult_disp", display_val, 9999);
    checkOutput("mult_a", operator1, 0);

    // Negative difference and divide by zero
    key(15); keys(7, 11, 9, 14); idle(3);
    @(negedge clk);
    checkOutput("sub_err", err, 1);
    checkOutput("sub_disp", display_val, 9999);
    key(15); keys(5, 13, 0, 14); idle(3);
    @(negedge clk);
    checkOutput("div_err", err, 1);
    checkOutput("div_disp", display_val, 9999);

    // Chaining from a shown result
    key(15); keys(6, 12, 7, 14); idle(3);
    @(negedge clk);
    checkOutput("chain_first", display_val, 42);
    key(10); key(8); key(14);
    @(negedge clk);
    checkOutput("chain_a", operator1, 42);
    idle(3);
    @(negedge clk);
    checkOutput("chain_result", display_val, 50);

    // Operator replacement and equals with no B digits
    key(15); key(3); key(10); key(11);
    @(negedge clk);
    checkOutput("replace_op", operation_val, 1);
    checkOutput("replace_no_exec", op_enable, 0);
    key(14); idle(3);
    @(negedge clk);
    checkOutput("empty_eq_busy", busy, 0);
    key(2); key(14); idle(3);
    @(negedge clk);
    checkOutput("replace_result", display_val, 1);

    // Clear while busy is ignored; reset during WAIT drops the result
    key(15); keys(4, 10, 5, 14); key(15); idle(2);
    @(negedge clk);
    checkOutput("busy_clear", display_val, 9);
    key(15); keys(1, 10, 2, 14); idle(1);
    applyStimulus(1'b0, 0, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("wait_rst_disp", display_val, 0);
    checkOutput("wait_rst_busy", busy, 0);
    checkOutput("wait_rst_a", operator1, 0);

    // Random keys, mostly valid, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
